// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV / DIVU.
//
// Takes a request through a start/busy/done handshake. Each request runs
// one restoring step per clock for WIDTH clocks, then one clock to apply
// signs, so latency is fixed at WIDTH+1 clocks from acceptance to done_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; aborts a division in flight
//   start_i      request a division (sampled only while idle)
//   signed_i     1 = DIV (two's complement), 0 = DIVU
//   dividend_i   dividend
//   divisor_i    divisor
//   busy_o       division in progress
//   done_o       one-cycle pulse, results valid and updated
//   quotient_o   quotient (LO), held until the next done_o
//   remainder_o  remainder (HI), held until the next done_o
//   div_zero_o   completed operation had a zero divisor
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; operands latched on accept
// RUN   | one restoring step per clock, step counter 0..WIDTH-1
// FIX   | apply result signs / divide-by-zero result, pulse done_o
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_orig;
  logic             sgn_mode;
  logic             sq;
  logic             sr;
  logic             dz;

  // Operand magnitudes at accept time. The most negative value negates to
  // itself, which read as unsigned is exactly its magnitude.
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign sa    = signed_i & dividend_i[WIDTH-1];
  assign sb    = signed_i & divisor_i[WIDTH-1];
  assign a_mag = sa ? (~dividend_i + 1'b1) : dividend_i;
  assign b_mag = sb ? (~divisor_i + 1'b1) : divisor_i;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor
  // from the WIDTH+1 bit partial remainder; a clear sign bit means keep.
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;
  logic           keep;

  assign partial = {rem, quo[WIDTH-1]};
  assign diff    = partial - {1'b0, dvs};
  assign keep    = ~diff[WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      step        <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      dvd_orig    <= '0;
      sgn_mode    <= 1'b0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      dz          <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            rem      <= '0;
            quo      <= a_mag;
            dvs      <= b_mag;
            dvd_orig <= dividend_i;
            sgn_mode <= signed_i;
            sq       <= sa ^ sb;
            sr       <= sa;
            dz       <= (divisor_i == '0);
            step     <= '0;
            busy_o   <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (keep) begin
            rem <= diff[WIDTH-1:0];
          end else begin
            rem <= partial[WIDTH-1:0];
          end
          quo  <= {quo[WIDTH-2:0], keep};
          step <= step + 1'b1;
          if (step == STEP_LAST) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (dz) begin
            // Zero divisor: fixed all-ones quotient, dividend passed back
            // unchanged (with its original sign) as the remainder.
            quotient_o  <= '1;
            remainder_o <= dvd_orig;
          end else begin
            quotient_o  <= (sgn_mode && sq) ? (~quo + 1'b1) : quo;
            remainder_o <= (sgn_mode && sr) ? (~rem + 1'b1) : rem;
          end
          div_zero_o <= dz;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_zero_o;

  div_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
    bit          gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected result per done_o, checks results, latency,
  // busy width and, when flagged, the spacing from the previous done_o.
  int busy_run  = 0;
  int prev_done = -1000;
  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done_o=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient_o, e.q);
        check("remainder", remainder_o, e.r);
        check("div_zero", {31'd0, div_zero_o}, {31'd0, e.dz});
        check("latency", cyc - e.acc, 33);
        check("busy_cycles", busy_run, 33);
        check("busy_at_done", {31'd0, busy_o}, 32'd0);
        if (e.gap) check("done_spacing", cyc - prev_done, 34);
      end
      prev_done = cyc;
      busy_run  = 0;
    end else if (busy_o) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Called at a negedge: present a request for one clock, push its result.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input bit gap);
    exp_t e;
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    e.q = eq; e.r = er; e.dz = ez; e.acc = cyc + 1; e.gap = gap;
    sb.push_back(e);
    @(negedge clk_i);
    start_i    = 1'b0;
    signed_i   = ~sgn;
    dividend_i = $urandom;
    divisor_i  = $urandom;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk_i);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 60 && !done_o; k++) @(negedge clk_i);
    if (!done_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got done_o=0 expected 1 within 60 cycles");
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_quotient"}, quotient_o, 32'd0);
    check({tag, "_remainder"}, remainder_o, 32'd0);
    check({tag, "_div_zero"}, {31'd0, div_zero_o}, 32'd0);
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check_zero_outputs("reset");
    @(negedge clk_i);

    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);                       drain();
    issue(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);     drain();
    issue(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 0);            drain();
    issue(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0);            drain();
    issue(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 0);     drain();
    issue(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 0);     drain();
    issue(1, 32'hFFFFFFF6, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF6, 1, 0);     drain();
    issue(0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0);                          drain();

    // Stray start mid-operation must be ignored; then a start in the
    // done_o cycle is accepted immediately.
    issue(0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 0);
    repeat (9) @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd7; divisor_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done();
    issue(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 1);
    drain();

    // Reset in the middle of RUN: outputs clear, no done_o afterwards.
    issue(0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 0);
    repeat (15) @(negedge clk_i);
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    check_zero_outputs("midrst");
    repeat (40) @(negedge clk_i);

    issue(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0);     drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider implementing DIV/DIVU for the CPU datapath.
- It pairs with the single-cycle ALU: the ALU handles all one-cycle operations, and this block handles division, which needs many cycles.
- It takes operands through a start/busy/done handshake, runs one restoring-division step per clock, and returns quotient and remainder for the HI/LO registers.

Parameters:
- WIDTH, 32, operand/result width. The iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  request a division; sampled only when busy_o=0
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; latched on accept
- dividend_i  input  WIDTH  dividend; latched on accept
- divisor_i  input  WIDTH  divisor; latched on accept
- busy_o  output  1  high while a division is in progress
- done_o  output  1  one-cycle pulse: results are valid and updated
- quotient_o  output  WIDTH  quotient (to LO); holds until the next done_o
- remainder_o  output  WIDTH  remainder (to HI); holds until the next done_o
- div_zero_o  output  1  divisor was 0 for the completed operation; holds with the results

Behaviour:
- Reset: one cycle of rst_i=1 sets state=IDLE and clears every output to 0: busy_o, done_o, quotient_o, remainder_o, div_zero_o.
- Reset mid-operation aborts the division. No done_o is produced and the internal registers are discarded.
- States:
  - IDLE
    - If start_i=1, latch the operands and signed_i, go to RUN, and set busy_o=1 from the next cycle.
    - Latching stores the magnitudes when signed_i=1, plus sign flags sq = sa^sb and sr = sa.
    - |0x80000000| is taken as unsigned 0x80000000.
  - RUN
    - Each cycle performs one restoring step: shift {rem, quo} left 1, trial-subtract the divisor magnitude from rem[WIDTH:0], and keep the result with quotient bit 1 if it is non-negative.
    - A step counter 0..WIDTH-1 tracks progress. After step WIDTH-1, go to FIX.
  - FIX
    - Apply signs: negate the quotient if sq, negate the remainder if sr, in signed mode only.
    - Write the results to the output registers, set done_o=1 and busy_o=0 for the next cycle, and return to IDLE.
- Latency:
  - Fixed regardless of operands.
  - start accepted at edge E0; RUN steps at edges E1..E32; FIX at E33; done_o high during the cycle after E33, i.e. 33 clocks after acceptance.
  - busy_o is high for the cycles after E0 through E33.
- Handshake:
  - start_i is ignored while busy_o=1. No queuing and no effect on the operation in flight.
  - start_i=1 in the same cycle done_o=1 is accepted, since the state is IDLE. Back-to-back throughput is one result per 34 cycles.
  - done_o is exactly one cycle wide.
- Divide by zero:
  - Runs the full latency.
  - Result: quotient_o=all ones, remainder_o=original dividend_i (original sign, not the magnitude), div_zero_o=1.
  - The sign fix is bypassed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0, with no flag.
- Sign rules: truncation toward zero. The remainder takes the sign of the dividend, and a zero remainder stays 0.
- Input operands may change freely after acceptance.

Test Plan:
- DIVU 100 / 7 with start at cycle 0 -> done_o pulses exactly 33 cycles later; quotient 14, remainder 2; busy_o high 33 cycles; div_zero_o=0.
- DIV -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Then DIV 7 / -2 -> quotient -3, remainder 1.
- DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0. DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- DIV 0xFFFFFFF6 / 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFF6, div_zero_o=1. Next DIVU 9/3 -> div_zero_o clears with results 3, 0.
- start_i pulsed at cycle 10 of a running 50/5 with different operands -> ignored; result 10, 0. A start asserted during the done_o cycle -> accepted, with the second done_o 34 cycles after the first.
- rst_i asserted at RUN step 15 -> all outputs 0 the next cycle, no done_o. A new start afterward completes normally with full 33-cycle latency.
